// File: rtl/snake_game_sequencer_if.sv
// Apple respawn handshake between the game sequencer (master) and the
// random coordinate generator (slave). rand_req holds until the first
// cycle with rand_valid=1; rand_x/rand_y are taken in that cycle.
interface snake_game_sequencer_if;
  logic       rand_req;
  logic [9:0] rand_x;
  logic [9:0] rand_y;
  logic       rand_valid;

  modport master (output rand_req, input rand_x, rand_y, rand_valid);
  modport slave  (input rand_req, output rand_x, rand_y, rand_valid);
endinterface

// File: rtl/snake_game_sequencer.sv
// snake_game_sequencer: IDLE/PLAY/PAUSE/OVER game FSM, velocity-scaled
// move_tick generator, once-per-move apple/collision judge, score keeping
// and apple respawn requests.
// Optional feature macro SNAKE_SPEEDUP_EN: velocity climbs with apples eaten
// and shortens the move period. Undefined: velocity fixed at 2, period fixed
// at BASE_PERIOD.
module snake_game_sequencer #(
  parameter int unsigned BASE_PERIOD      = 50_000_000,
  parameter int unsigned PERIOD_STEP      = 5_000_000,
  parameter int unsigned MIN_PERIOD       = 10_000_000,
  parameter int unsigned APPLES_PER_LEVEL = 6,
  parameter int unsigned VEL_MAX          = 10,
  parameter int unsigned MAX_LEN          = 999
) (
  input  logic                   clock_100Mhz,
  input  logic                   reset,
  input  logic                   start_btn_i,
  input  logic                   pause_btn_i,
  input  logic [9:0]             head_x_i,
  input  logic [9:0]             head_y_i,
  input  logic                   collision_i,
  snake_game_sequencer_if.master rnd_if,
  output logic [9:0]             apple_x_o,
  output logic [9:0]             apple_y_o,
  output logic                   move_tick_o,
  output logic                   game_reset_o,
  output logic                   apple_eaten_o,
  output logic [9:0]             length_o,
  output logic [7:0]             velocity_o,
  output logic [19:0]            score_o,
  output logic [19:0]            high_score_o,
  output logic [1:0]             state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_PAUSE = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  localparam logic [9:0]  APPLE_X0  = 10'd160;
  localparam logic [9:0]  APPLE_Y0  = 10'd320;
  localparam logic [20:0] SCORE_MAX = 21'd9999;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        tick_q, tick_d;
  logic        eval_q;
  logic        start_q, pause_q;
  logic [9:0]  apple_x_q, apple_x_d, apple_y_q, apple_y_d;
  logic        req_q, req_d;
  logic [9:0]  len_q, len_d;
  logic [19:0] score_q, score_d, hs_q;
  logic        gr_q, gr_d, eat_q, eat_d;
  logic [7:0]  vel;
  logic [31:0] period;
  logic        start_e, pause_e, hit;
  logic [8:0]  incr;
  logic [20:0] sum;

`ifdef SNAKE_SPEEDUP_EN
  logic [7:0]  vel_q, vel_d;
  logic [7:0]  apl_q, apl_d;
  logic [31:0] dec;

  assign vel = vel_q;

  // Move period shrinks by PERIOD_STEP per velocity level, floored at MIN_PERIOD.
  always_comb begin
    dec = 32'(vel - 8'd2) * PERIOD_STEP;
    if (dec >= BASE_PERIOD || (BASE_PERIOD - dec) < MIN_PERIOD) period = MIN_PERIOD;
    else                                                          period = BASE_PERIOD - dec;
  end
`else
  logic unused_cfg;

  assign vel        = 8'd2;
  assign period     = BASE_PERIOD;
  assign unused_cfg = ^{PERIOD_STEP, MIN_PERIOD, APPLES_PER_LEVEL, VEL_MAX};
`endif

  assign start_e = start_btn_i & ~start_q;
  assign pause_e = pause_btn_i & ~pause_q;

  // 11-bit compares so an apple near 0 cannot wrap into a false hit.
  always_comb begin
    hit = !req_q
       && (11'(head_x_i) + 11'd4 >= 11'(apple_x_q)) && (11'(head_x_i) <= 11'(apple_x_q) + 11'd4)
       && (11'(head_y_i) + 11'd4 >= 11'(apple_y_q)) && (11'(head_y_i) <= 11'(apple_y_q) + 11'd4);
  end

  assign incr = (vel < 8'd6) ? {1'b0, vel} : {vel, 1'b0};
  assign sum  = 21'(score_q) + 21'(incr);

  // Next-state: FSM, move judge, respawn handshake and tick counter.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    apple_x_d = apple_x_q;
    apple_y_d = apple_y_q;
    req_d     = req_q;
    len_d     = len_q;
    score_d   = score_q;
    gr_d      = 1'b0;
    eat_d     = 1'b0;
`ifdef SNAKE_SPEEDUP_EN
    vel_d     = vel_q;
    apl_d     = apl_q;
`endif
    tick_d    = (state_q == S_PLAY) && (cnt_q >= period - 32'd1);

    // Handshake runs in every state so a respawn can finish during PAUSE.
    if (req_q && rnd_if.rand_valid) begin
      apple_x_d = rnd_if.rand_x;
      apple_y_d = rnd_if.rand_y;
      req_d     = 1'b0;
    end

    case (state_q)
      S_IDLE, S_OVER: begin
        if (start_e) begin
          state_d   = S_PLAY;
          gr_d      = 1'b1;
          score_d   = '0;
          len_d     = '0;
          apple_x_d = APPLE_X0;
          apple_y_d = APPLE_Y0;
          req_d     = 1'b0;
`ifdef SNAKE_SPEEDUP_EN
          vel_d     = 8'd2;
          apl_d     = '0;
`endif
        end
      end
      S_PLAY: begin
        if (eval_q && collision_i) begin
          state_d = S_OVER;
        end else begin
          if (pause_e) state_d = S_PAUSE;
          if (eval_q && hit) begin
            eat_d   = 1'b1;
            req_d   = 1'b1;
            if (32'(len_q) < MAX_LEN) len_d = len_q + 10'd1;
            score_d = (sum > SCORE_MAX) ? SCORE_MAX[19:0] : sum[19:0];
`ifdef SNAKE_SPEEDUP_EN
            if (32'(apl_q) + 32'd1 >= APPLES_PER_LEVEL) begin
              apl_d = '0;
              if (32'(vel_q) < VEL_MAX) vel_d = vel_q + 8'd1;
            end else begin
              apl_d = apl_q + 8'd1;
            end
`endif
          end
        end
      end
      S_PAUSE: begin
        if (pause_e) state_d = S_PLAY;
      end
      default: ;
    endcase

    // Counter only advances in PLAY; idle/over force it to zero.
    if (state_d == S_IDLE || state_d == S_OVER) cnt_d = '0;
    else if (state_q == S_PLAY)                 cnt_d = tick_d ? '0 : cnt_q + 32'd1;
  end

  // Game state registers.
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      tick_q    <= 1'b0;
      eval_q    <= 1'b0;
      start_q   <= 1'b0;
      pause_q   <= 1'b0;
      apple_x_q <= APPLE_X0;
      apple_y_q <= APPLE_Y0;
      req_q     <= 1'b0;
      len_q     <= '0;
      score_q   <= '0;
      gr_q      <= 1'b0;
      eat_q     <= 1'b0;
`ifdef SNAKE_SPEEDUP_EN
      vel_q     <= 8'd2;
      apl_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tick_q    <= tick_d;
      eval_q    <= tick_q;
      start_q   <= start_btn_i;
      pause_q   <= pause_btn_i;
      apple_x_q <= apple_x_d;
      apple_y_q <= apple_y_d;
      req_q     <= req_d;
      len_q     <= len_d;
      score_q   <= score_d;
      gr_q      <= gr_d;
      eat_q     <= eat_d;
`ifdef SNAKE_SPEEDUP_EN
      vel_q     <= vel_d;
      apl_q     <= apl_d;
`endif
    end
  end

  // High score trails score by one cycle and survives new games, not reset.
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset)                 hs_q <= '0;
    else if (score_q > hs_q)   hs_q <= score_q;
  end

  assign rnd_if.rand_req = req_q;
  assign apple_x_o       = apple_x_q;
  assign apple_y_o       = apple_y_q;
  assign move_tick_o     = tick_q;
  assign game_reset_o    = gr_q;
  assign apple_eaten_o   = eat_q;
  assign length_o        = len_q;
  assign velocity_o      = vel;
  assign score_o         = score_q;
  assign high_score_o    = hs_q;
  assign state_o         = state_q;

endmodule

// File: doc/snake_game_sequencer.md
# snake_game_sequencer

Game-level sequencer for the snake datapath in the 100 MHz domain. It replaces the free-running 1 Hz move clock with a velocity-scaled `move_tick` enable and runs the IDLE/PLAY/PAUSE/OVER state machine. It also judges apple hits and collisions once per move, updates length, score, high score and velocity, and requests new apple coordinates from the random generator through a req/valid handshake. Its outputs feed the position controller, the VGA controller, the scoreboard and the sound block.

## Interface
- BASE_PERIOD, 50_000_000: move period in cycles at velocity 2.
- PERIOD_STEP, 5_000_000: period reduction per velocity step above 2.
- MIN_PERIOD, 10_000_000: lower bound on the move period.
- APPLES_PER_LEVEL, 6: apples eaten per velocity increment.
- VEL_MAX, 10: velocity saturation value.
- MAX_LEN, 999: length saturation value.
- clock_100Mhz  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- start_btn  in  1  synchronized level; its rising edge starts a game.
- pause_btn  in  1  synchronized level; its rising edge toggles pause.
- head_x, head_y  in  10  current snake head position.
- collision  in  1  wall or self hit from the position controller.
- rand_x, rand_y  in  10  candidate apple position.
- rand_valid  in  1  candidate is valid.
- rand_req  out  1  apple respawn request.
- apple_x, apple_y  out  10  current apple position.
- move_tick  out  1  one-cycle snake step enable.
- game_reset  out  1  one-cycle pulse that clears the snake body.
- apple_eaten  out  1  one-cycle pulse to the sound block.
- length  out  10  body segments.
- velocity  out  8  speed level.
- score, high_score  out  20  binary scores.
- state  out  2  encoding: IDLE=0, PLAY=1, PAUSE=2, OVER=3.

## Operation
- **Reset values:** state IDLE; all pulses 0; rand_req 0; length 0; score 0; high_score 0; velocity 2; apple (160,320); tick counter 0; apple-count counter 0.
- **Edge detection:** start_btn and pause_btn pass through one-cycle-delayed edge detectors.
- **Start:** a start edge in IDLE or OVER does all of the following and enters PLAY:
  - pulses game_reset;
  - clears score, length and the tick and apple-count counters;
  - sets velocity to 2 and the apple to (160,320);
  - drops any pending rand_req;
  - retains high_score.
- **Pause:** a pause edge toggles PLAY↔PAUSE. It is ignored in IDLE and OVER. Start edges in PLAY or PAUSE are ignored. When both edges arrive in IDLE or OVER, start wins.
- **Move period:** `period = max(MIN_PERIOD, BASE_PERIOD − (velocity−2)·PERIOD_STEP)`, using 32-bit unsigned arithmetic with no underflow.
- **Tick counter:**
  - Increments only in PLAY.
  - At `period−1` it emits move_tick and wraps to 0.
  - Holds its value in PAUSE.
  - Is zero in IDLE and OVER.
- **Move evaluation:** runs in the cycle after move_tick.
  - **Collision:** collision=1 → state OVER. Collision beats an apple hit; no score is awarded.
  - **Apple hit:** the head is within ±4 of the apple on both axes and no respawn is pending. Compare in 11 bits with `head+4 ≥ apple` and `head ≤ apple+4`, so there is no wrap at apple<4.
- **On an apple hit:**
  - pulse apple_eaten;
  - length += 1, saturating at MAX_LEN;
  - score += velocity if velocity<6, else score += 2·velocity; score saturates at 9999;
  - advance the apple-count counter; when it reaches APPLES_PER_LEVEL it resets to 0 and velocity += 1, saturating at VEL_MAX;
  - assert rand_req.
- **Respawn handshake:**
  - rand_req holds until the first cycle with rand_valid=1. In that cycle, apple_x/apple_y latch rand_x/rand_y and rand_req drops.
  - rand_valid while rand_req=0 is ignored.
  - The handshake keeps running during PAUSE.
  - Hit checks are suppressed while rand_req=1.
- **High score:** when score > high_score, high_score loads score on the next cycle, in any state.

## Timing
- With move_tick high in cycle T:
  - head and collision are sampled in T+1;
  - state, length, score, velocity, apple_eaten and rand_req change at T+2;
  - high_score changes no earlier than T+3.
- The first move_tick comes `period` cycles after the PLAY entry cycle.
- A velocity change takes effect on the next counter wrap. The counter value is not rescaled.
- Resuming from PAUSE continues the count from where it stopped. No extra tick is issued.
- Asserting reset mid-game clears everything immediately, high_score included.

## Configuration
- `SNAKE_SPEEDUP_EN` defined: velocity and the move period scale with apples eaten, as described in Operation.
- `SNAKE_SPEEDUP_EN` undefined:
  - velocity is constant at 2 and the period is constant at BASE_PERIOD;
  - the apple-count counter is removed;
  - the scoring rule is unchanged (always +2 per apple).

## Test plan
Parameters for all scenarios: BASE_PERIOD=20, PERIOD_STEP=4, MIN_PERIOD=8, APPLES_PER_LEVEL=2, VEL_MAX=4.
- **Ticks and pause:** reset, start edge → state=1, game_reset 1 cycle, move_tick every 20 cycles. A pause edge mid-count → state=2 and ticks stop. A second pause edge → the count resumes and the next tick arrives after the remaining cycles only.
- **Apple hit at offset +4:** head (164,316), apple (160,320) on a tick → apple_eaten, length=1, score=2, rand_req=1. rand_valid with (300,200) 5 cycles later → apple=(300,200), rand_req=0. Hit checks stay blocked during those 5 cycles.
- **Speed-up sequence:** 4 apples → velocity 2→3→4, period 20→16→12. Score = 2+2+3+3 = 10. A 5th and 6th apple leave velocity at 4 (saturated).
- **Collision beats hit:** collision=1 and an apple hit on the same tick → state=3, no apple_eaten, score unchanged. A start edge then clears score to 0, keeps high_score=10, and returns to state 1.
- **Low-coordinate apple:** apple (2,2), head (0,0) → hit detected. Head (7,0) → no hit. There is no underflow false hit.
- **Reset mid-respawn:** reset asserted while rand_req=1 → all outputs return to their reset values the same cycle, rand_valid is then ignored, and high_score=0.
